alu_pipe_gen2: RTL and testbench
================================

# alu_pipe_gen2

Parametrised, registered ALU for the RIPTIDE-III CPU execute stage, and the successor to the fixed 8-bit ALU. It keeps the legacy 3-bit op encoding bit-exact in the lower half of a 4-bit op space. It adds subtract, add-with-carry, OR, logical/arithmetic shifts, a zero flag, and an iterative unsigned multiply with a `busy` handshake. All results are registered; `data_hazard` stalls operation acceptance exactly as in the current pipeline.

## Interface

Parameters:
- `WIDTH`, default 8: datapath width. Must be a power of two, 4 to 32.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width. Derived; do not override.

Ports:
- `clk` input 1: the only clock. All state updates on the rising edge.
- `rst` input 1: reset. Synchronous, active-high.
- `data_hazard` input 1: when high, no new op is accepted and result/flag registers hold. An in-flight multiply still advances.
- `op` input 4: operation select. Encoding is under Operation.
- `in_a` input WIDTH: operand A.
- `in_b` input WIDTH: operand B; for shifts, `in_b[SHW-1:0]` is the shift amount.
- `alu_out` output WIDTH: registered result.
- `OVF_out` output 1: registered carry/borrow flag.
- `Z_out` output 1: registered zero flag; equals (`alu_out` == 0) after every result write.
- `busy` output 1: high while a multiply is in progress.

## Operation

- Accept condition per edge: `~rst & ~data_hazard & ~busy`. A non-accepted edge leaves `alu_out`, `OVF_out` and `Z_out` unchanged, except at multiply completion.
- Legacy ops, bit-identical to the previous ALU:
  - 0000: A.
  - 0001: A+B; OVF = carry out.
  - 0010: A&B.
  - 0011: A^B.
  - 0100: B.
  - 0101: A+B, OVF unchanged.
  - 0110: A&B.
  - 0111: A^B.
- New ops:
  - 1000 SUB: A−B mod 2^WIDTH; OVF = borrow (1 iff A<B unsigned).
  - 1001 SHL: A << `in_b[SHW-1:0]`, zero fill.
  - 1010 SHR: A >> amount, zero fill.
  - 1011 SAR: A >> amount, sign fill from A[WIDTH-1].
  - 1100 OR: A|B.
  - 1101 ADC: A+B+OVF_out; OVF = carry out. Uses the OVF value registered before this edge.
  - 1110 MULL: low WIDTH bits of unsigned A×B. Multi-cycle.
  - 1111 MULH: high WIDTH bits of unsigned A×B. Multi-cycle.
- OVF is written only by 0001, 1000 and 1101. Every other op leaves it unchanged.
- Z is written with every `alu_out` write, including multiply completion.
- Multiply FSM, states IDLE and RUN:
  - IDLE→RUN on acceptance of 1110/1111. Latch A, B and the high/low select; clear the 2·WIDTH accumulator; load `count`=WIDTH; assert `busy`.
  - RUN, each edge: shift-add one multiplier bit, LSB first; decrement `count`.
  - On the edge where `count` reaches 0: write the selected half to `alu_out`, update Z, return to IDLE, deassert `busy`.
  - In RUN, `op`, `in_a`, `in_b` and `data_hazard` are ignored.
- Reset, at any time including mid-multiply:
  - `alu_out`=0, `OVF_out`=0, `Z_out`=1, `busy`=0, FSM=IDLE.
  - The aborted multiply produces no result.

## Timing

- Single-cycle ops: accepted at edge N; `alu_out`/flags valid after edge N (1-cycle latency, same as the legacy ALU).
- Multiply: accepted at edge N; `busy`=1 after edge N; iterations at edges N+1..N+WIDTH. Result, Z update and `busy`=0 all appear after edge N+WIDTH.
- `busy` is high for exactly WIDTH cycles. `alu_out` holds its previous value until completion.
- First new op can be accepted at edge N+WIDTH+1. An op presented at edge N+WIDTH itself is not accepted, because `busy` is still 1 before that edge.
- `data_hazard` high on the accept edge: the op is not taken and no state changes. The op is accepted on the first edge with `data_hazard` low.
- `rst` and accept on the same edge: reset wins.

## Test plan

- Reset, then WIDTH=8, op 0001, A=0xF0, B=0x20 → `alu_out`=0x10, OVF=1, Z=0. Next, op 0101, A=0x80, B=0x80 → `alu_out`=0x00, OVF stays 1, Z=1.
- ADC chain: op 1000, A=0x05, B=0x07 → 0xFE, OVF=1. Then op 1101, A=0x01, B=0x01 → 0x03, OVF=0.
- Shifts, A=0x90, amount 3: SHL → 0x80; SHR → 0x12; SAR → 0xF2. OVF unchanged throughout.
- MULH, A=0xFF, B=0xFF → `busy` high exactly 8 cycles, `alu_out` = 0xFE after edge N+8. Ops driven during `busy` are ignored. MULL with the same operands → 0x01.
- `data_hazard` held high for 3 cycles with op 0100, B=0x5A → `alu_out` unchanged; after release → 0x5A on the next edge.
- Mid-multiply reset at cycle 4 of MULL → all outputs at reset values and `busy`=0 the next cycle. A subsequent single-cycle op is accepted immediately.
- Repeat the first four scenarios with WIDTH=16, using scaled values, against a reference model.

Source files
------------

// File: rtl/alu_pipe_gen2.sv
// alu_pipe_gen2: registered execute-stage ALU with an iterative unsigned
// multiplier. Ops 0000-0111 behave like the original fixed-width ALU. Ops
// 1000-1111 add subtract, shifts, OR, add-with-carry and a shift-add multiply
// that holds busy high for WIDTH cycles.
module alu_pipe_gen2 #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_hazard,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] alu_out,
  output logic             OVF_out,
  output logic             Z_out,
  output logic             busy
);

  localparam int CW = SHW + 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               hiSel_q, hiSel_d;
  logic [CW-1:0]      count_q, count_d;

  logic [SHW-1:0]     shAmt;
  logic [WIDTH:0]     addSum;
  logic [WIDTH:0]     adcSum;
  logic [WIDTH:0]     subDiff;
  logic [WIDTH-1:0]   sarRes;
  logic               isMul;
  logic [WIDTH-1:0]   aluRes;
  logic               aluOvf;
  logic               aluOvfWe;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     stepSum;
  logic [2*WIDTH-1:0] stepAcc;

  assign shAmt   = in_b[SHW-1:0];
  assign addSum  = {1'b0, in_a} + {1'b0, in_b};
  assign adcSum  = addSum + {{WIDTH{1'b0}}, ovf_q};
  assign subDiff = {1'b0, in_a} - {1'b0, in_b};
  assign sarRes  = $unsigned($signed(in_a) >>> shAmt);
  assign isMul   = op[3] & op[2] & op[1];

  // One shift-add step: add the multiplicand into the upper half when the
  // current multiplier LSB is set, then shift the whole accumulator right.
  assign addend  = mplier_q[0] ? mcand_q : '0;
  assign stepSum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign stepAcc = {stepSum, acc_q[WIDTH-1:1]};

  // Single-cycle datapath: result and carry/borrow for the op on the inputs.
  always_comb begin
    aluRes   = '0;
    aluOvf   = ovf_q;
    aluOvfWe = 1'b0;
    case (op)
      4'b0000: aluRes = in_a;
      4'b0001: begin
        {aluOvf, aluRes} = addSum;
        aluOvfWe         = 1'b1;
      end
      4'b0010, 4'b0110: aluRes = in_a & in_b;
      4'b0011, 4'b0111: aluRes = in_a ^ in_b;
      4'b0100: aluRes = in_b;
      4'b0101: aluRes = addSum[WIDTH-1:0];
      4'b1000: begin
        {aluOvf, aluRes} = subDiff;
        aluOvfWe         = 1'b1;
      end
      4'b1001: aluRes = in_a << shAmt;
      4'b1010: aluRes = in_a >> shAmt;
      4'b1011: aluRes = sarRes;
      4'b1100: aluRes = in_a | in_b;
      4'b1101: begin
        {aluOvf, aluRes} = adcSum;
        aluOvfWe         = 1'b1;
      end
      default: aluRes = '0;
    endcase
  end

  // Accept/multiply FSM: decides what each register loads on the next edge.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    hiSel_d  = hiSel_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (!data_hazard) begin
          if (isMul) begin
            state_d  = RUN;
            mcand_d  = in_a;
            mplier_d = in_b;
            hiSel_d  = op[0];
            acc_d    = '0;
            count_d  = CW'(WIDTH);
          end else begin
            result_d = aluRes;
            zero_d   = (aluRes == '0);
            if (aluOvfWe) begin
              ovf_d = aluOvf;
            end
          end
        end
      end
      RUN: begin
        acc_d    = stepAcc;
        mplier_d = mplier_q >> 1;
        count_d  = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d  = IDLE;
          result_d = hiSel_q ? stepAcc[2*WIDTH-1:WIDTH] : stepAcc[WIDTH-1:0];
          zero_d   = hiSel_q ? (stepAcc[2*WIDTH-1:WIDTH] == '0)
                             : (stepAcc[WIDTH-1:0] == '0);
        end
      end
    endcase
  end

  // State registers; reset abandons any multiply in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b1;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      hiSel_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      hiSel_q  <= hiSel_d;
      count_q  <= count_d;
    end
  end

  assign alu_out = result_q;
  assign OVF_out = ovf_q;
  assign Z_out   = zero_q;
  assign busy    = (state_q == RUN);

endmodule

// File: tb/tb_alu_pipe_gen2.sv
// tb_alu_pipe_gen2: directed vectors for an 8-bit instance, hand-written
// multi-cycle sequences, and a 16-bit instance checked against a small model.
module tb_alu_pipe_gen2;

  logic        clk = 1'b0;
  logic        rst;
  logic        hz, hz16;
  logic [3:0]  op, op16;
  logic [7:0]  a, b, out;
  logic [15:0] a16, b16, out16;
  logic        ovf, z, busy, ovf16, z16, busy16;

  int errors = 0;
  int checks = 0;

  logic [15:0] m16Out;
  logic        m16Ovf;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] expOut;
    logic       expOvf;
    logic       expZ;
  } vec_t;

  vec_t vecs[$];

  // Free-running clock shared by both instances.
  always #5 clk = ~clk;

  alu_pipe_gen2 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .data_hazard(hz), .op(op), .in_a(a), .in_b(b),
    .alu_out(out), .OVF_out(ovf), .Z_out(z), .busy(busy)
  );

  alu_pipe_gen2 #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .data_hazard(hz16), .op(op16), .in_a(a16), .in_b(b16),
    .alu_out(out16), .OVF_out(ovf16), .Z_out(z16), .busy(busy16)
  );

  // Hard stop in case something never settles.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [3:0] o, input logic [7:0] ia,
                               input logic [7:0] ib, input logic h);
    op = o; a = ia; b = ib; hz = h;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus16(input logic [3:0] o, input logic [15:0] ia,
                                 input logic [15:0] ib, input logic h);
    op16 = o; a16 = ia; b16 = ib; hz16 = h;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] eo,
                             input logic eovf, input logic ez, input logic eb);
    checks++;
    if (out !== eo || ovf !== eovf || z !== ez || busy !== eb) begin
      errors++;
      $display("[TB] FAIL %s: got out=%h ovf=%b z=%b busy=%b, want out=%h ovf=%b z=%b busy=%b",
               name, out, ovf, z, busy, eo, eovf, ez, eb);
    end
  endtask

  task automatic checkOutput16(input string name, input logic [15:0] eo,
                               input logic eovf, input logic eb);
    logic ez;
    ez = (eo == 16'h0000);
    checks++;
    if (out16 !== eo || ovf16 !== eovf || z16 !== ez || busy16 !== eb) begin
      errors++;
      $display("[TB] FAIL %s: got out=%h ovf=%b z=%b busy=%b, want out=%h ovf=%b z=%b busy=%b",
               name, out16, ovf16, z16, busy16, eo, eovf, ez, eb);
    end
  endtask

  // Reference behaviour of the 16-bit ALU, built from plain integer arithmetic.
  task automatic model16(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    logic [63:0] ux, uy, t, p;
    int sh;
    ux = 64'(x);
    uy = 64'(y);
    sh = int'(y[3:0]);
    p  = ux * uy;
    case (o)
      4'd0: m16Out = x;
      4'd1: begin t = ux + uy; m16Out = t[15:0]; m16Ovf = (t > 64'hFFFF); end
      4'd2, 4'd6: m16Out = x & y;
      4'd3, 4'd7: m16Out = x ^ y;
      4'd4: m16Out = y;
      4'd5: begin t = ux + uy; m16Out = t[15:0]; end
      4'd8: begin t = ux - uy; m16Out = t[15:0]; m16Ovf = (ux < uy); end
      4'd9: begin t = ux << sh; m16Out = t[15:0]; end
      4'd10: m16Out = x >> sh;
      4'd11: m16Out = (x >> sh) | (x[15] ? ~(16'hFFFF >> sh) : 16'h0000);
      4'd12: m16Out = x | y;
      4'd13: begin t = ux + uy + 64'(m16Ovf); m16Out = t[15:0]; m16Ovf = (t > 64'hFFFF); end
      4'd14: m16Out = p[15:0];
      default: m16Out = p[31:16];
    endcase
  endtask

  // Run one op on the 16-bit instance and compare with the model, including
  // the busy duration for multiplies.
  task automatic run16(input string name, input logic [3:0] o,
                       input logic [15:0] x, input logic [15:0] y);
    logic [15:0] oldOut;
    int cnt;
    int guard;
    oldOut = m16Out;
    model16(o, x, y);
    applyStimulus16(o, x, y, 1'b0);
    if (o[3] & o[2] & o[1]) begin
      checkOutput16({name, "-accept"}, oldOut, m16Ovf, 1'b1);
      cnt = 0;
      guard = 0;
      while (busy16 && guard < 40) begin
        cnt++;
        guard++;
        applyStimulus16(4'b0100, 16'hAAAA, 16'h5555, 1'b0);
      end
      checks++;
      if (cnt != 16) begin
        errors++;
        $display("[TB] FAIL %s-busylen: got %0d cycles, want 16", name, cnt);
      end
    end
    checkOutput16(name, m16Out, m16Ovf, 1'b0);
  endtask

  initial begin
    // Stateful vector table: OVF/result carry from one row to the next.
    vecs.push_back('{4'b0001, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0});
    vecs.push_back('{4'b0101, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{4'b1000, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0});
    vecs.push_back('{4'b1101, 8'h01, 8'h01, 8'h03, 1'b0, 1'b0});
    vecs.push_back('{4'b1000, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0});
    vecs.push_back('{4'b1001, 8'h90, 8'h03, 8'h80, 1'b1, 1'b0});
    vecs.push_back('{4'b1010, 8'h90, 8'h03, 8'h12, 1'b1, 1'b0});
    vecs.push_back('{4'b1011, 8'h90, 8'h03, 8'hF2, 1'b1, 1'b0});
    vecs.push_back('{4'b1001, 8'h11, 8'h0B, 8'h88, 1'b1, 1'b0});
    vecs.push_back('{4'b1001, 8'h81, 8'h00, 8'h81, 1'b1, 1'b0});
    vecs.push_back('{4'b1011, 8'h81, 8'h07, 8'hFF, 1'b1, 1'b0});
    vecs.push_back('{4'b1010, 8'h81, 8'h07, 8'h01, 1'b1, 1'b0});
    vecs.push_back('{4'b0000, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{4'b0010, 8'hF0, 8'h3C, 8'h30, 1'b1, 1'b0});
    vecs.push_back('{4'b0110, 8'hF0, 8'h3C, 8'h30, 1'b1, 1'b0});
    vecs.push_back('{4'b0011, 8'hF0, 8'h3C, 8'hCC, 1'b1, 1'b0});
    vecs.push_back('{4'b0111, 8'hF0, 8'h3C, 8'hCC, 1'b1, 1'b0});
    vecs.push_back('{4'b0100, 8'h12, 8'h5A, 8'h5A, 1'b1, 1'b0});
    vecs.push_back('{4'b1100, 8'hF0, 8'h0F, 8'hFF, 1'b1, 1'b0});
    vecs.push_back('{4'b0001, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0});
    vecs.push_back('{4'b1101, 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0});
    vecs.push_back('{4'b1101, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{4'b1101, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0});
    vecs.push_back('{4'b0001, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{4'b1000, 8'h07, 8'h07, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{4'b1011, 8'h70, 8'h02, 8'h1C, 1'b0, 1'b0});

    rst = 1'b1;
    hz = 1'b0; op = 4'b0000; a = 8'h00; b = 8'h00;
    hz16 = 1'b1; op16 = 4'b0000; a16 = 16'h0000; b16 = 16'h0000;
    m16Out = 16'h0000;
    m16Ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset8", 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput16("reset16", 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      checkOutput($sformatf("vec%0d", i), vecs[i].expOut, vecs[i].expOvf, vecs[i].expZ, 1'b0);
    end

    // data_hazard holds everything, then the op lands on the first free edge.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0100, 8'h00, 8'h5A, 1'b1);
      checkOutput($sformatf("hazard%0d", i), 8'h1C, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(4'b0100, 8'h00, 8'h5A, 1'b0);
    checkOutput("hazard-release", 8'h5A, 1'b0, 1'b0, 1'b0);

    // Reset beats an op presented on the same edge.
    rst = 1'b1;
    applyStimulus(4'b0100, 8'h00, 8'h33, 1'b0);
    checkOutput("reset-wins", 8'h00, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;

    applyStimulus(4'b0001, 8'hFF, 8'h02, 1'b0);
    checkOutput("pre-mul", 8'h01, 1'b1, 1'b0, 1'b0);

    // MULH FF*FF = FE01: busy for exactly 8 edges, ops in between ignored.
    applyStimulus(4'b1111, 8'hFF, 8'hFF, 1'b0);
    checkOutput("mulh-accept", 8'h01, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(4'b0100, 8'h33, 8'h33, i[0]);
      if (i < 8) checkOutput($sformatf("mulh-busy%0d", i), 8'h01, 1'b1, 1'b0, 1'b1);
      else       checkOutput("mulh-done", 8'hFE, 1'b1, 1'b0, 1'b0);
    end

    applyStimulus(4'b1110, 8'hFF, 8'hFF, 1'b0);
    checkOutput("mull-accept", 8'hFE, 1'b1, 1'b0, 1'b1);
    repeat (8) applyStimulus(4'b1100, 8'hAA, 8'h55, 1'b0);
    checkOutput("mull-done", 8'h01, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0100, 8'h00, 8'h77, 1'b0);
    checkOutput("post-mul-accept", 8'h77, 1'b1, 1'b0, 1'b0);

    // 0x10*0x10 = 0x0100: low half zero sets Z, high half is 0x01.
    applyStimulus(4'b1110, 8'h10, 8'h10, 1'b0);
    repeat (8) applyStimulus(4'b0000, 8'h99, 8'h00, 1'b0);
    checkOutput("mull-zero", 8'h00, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b1111, 8'h10, 8'h10, 1'b0);
    repeat (8) applyStimulus(4'b0000, 8'h99, 8'h00, 1'b0);
    checkOutput("mulh-small", 8'h01, 1'b1, 1'b0, 1'b0);

    // A multiply presented under data_hazard is not started.
    applyStimulus(4'b1110, 8'h03, 8'h05, 1'b1);
    checkOutput("mul-hazard", 8'h01, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b1110, 8'h03, 8'h05, 1'b0);
    checkOutput("mul-after-hazard", 8'h01, 1'b1, 1'b0, 1'b1);
    repeat (8) applyStimulus(4'b0000, 8'h00, 8'h00, 1'b0);
    checkOutput("mul-3x5", 8'h0F, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a multiply: no result ever appears.
    applyStimulus(4'b1110, 8'h03, 8'h05, 1'b0);
    repeat (3) applyStimulus(4'b0000, 8'h00, 8'h00, 1'b0);
    rst = 1'b1;
    applyStimulus(4'b0000, 8'h00, 8'h00, 1'b0);
    checkOutput("mid-mul-reset", 8'h00, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    applyStimulus(4'b0001, 8'h02, 8'h03, 1'b0);
    checkOutput("after-reset-op", 8'h05, 1'b0, 1'b0, 1'b0);
    repeat (10) applyStimulus(4'b0000, 8'h00, 8'h00, 1'b1);
    checkOutput("no-stale-result", 8'h05, 1'b0, 1'b0, 1'b0);

    // 16-bit instance, scaled scenarios against the model.
    run16("w16-add", 4'd1, 16'hF000, 16'h2000);
    run16("w16-addnc", 4'd5, 16'h8000, 16'h8000);
    run16("w16-sub", 4'd8, 16'h0005, 16'h0007);
    run16("w16-adc", 4'd13, 16'h0001, 16'h0001);
    run16("w16-sub2", 4'd8, 16'h0000, 16'h0001);
    run16("w16-shl", 4'd9, 16'h9000, 16'h0003);
    run16("w16-shr", 4'd10, 16'h9000, 16'h0003);
    run16("w16-sar", 4'd11, 16'h9000, 16'h0003);
    run16("w16-mulh", 4'd15, 16'hFFFF, 16'hFFFF);
    run16("w16-mull", 4'd14, 16'hFFFF, 16'hFFFF);
    run16("w16-movb", 4'd4, 16'h0000, 16'h1234);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
